// File: rtl/demux_1ton_stream_if.sv
// Stream bundle for the 1-to-N demux: one producer-side input and N_OUT
// consumer-side output channels, each with its own valid/ready pair.
interface demux_1ton_stream_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2
);
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;

  // Environment side: drives the producer stream and the consumer readies.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Demux side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N stream demux with a one-entry holding register per channel,
// global enable, and a saturating counter for out-of-range selects.
module demux_1ton_stream #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  demux_1ton_stream_if.slave   bus,
  output logic                 drop_err,
  output logic [CNT_W-1:0]     drop_cnt
);

  logic [N_OUT-1:0]        vld_p1;
  logic [N_OUT*DATA_W-1:0] data_p1;
  logic                    sel_ok;
  logic                    chan_free;
  logic                    load_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Stage p0: acceptance decision, combinational from en, select and channel state
  always_comb begin
    chan_free = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (32'(bus.in_sel) == k) chan_free = !vld_p1[k] || bus.out_ready[k];
    end
    sel_ok       = 32'(bus.in_sel) < N_OUT;
    // Out-of-range selects are always accepted so they can be dropped.
    bus.in_ready = !rst && en && (!sel_ok || chan_free);
    load_p0      = bus.in_valid && bus.in_ready;
  end

  // Stage p1: per-channel holding registers and drop reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= '0;
      data_p1  <= '0;
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop_err <= load_p0 && !sel_ok;
      if (load_p0 && !sel_ok) drop_cnt <= sat_inc(drop_cnt);
      for (int k = 0; k < N_OUT; k++) begin
        // A load into a draining channel keeps it valid: one transfer per cycle.
        if (load_p0 && sel_ok && (32'(bus.in_sel) == k)) begin
          vld_p1[k]                   <= 1'b1;
          data_p1[k*DATA_W +: DATA_W] <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          vld_p1[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;

endmodule

// File: doc/demux_1ton_stream.md
Name: demux_1toN_stream

Overview:
- Parametrised, registered 1-to-N demultiplexer: the clocked successor to the team's combinational 1-to-4 demux.
- Routes one DATA_W-bit input stream to one of N_OUT output channels chosen by a per-transfer select.
- Uses valid/ready handshakes on the input and on every output, with a one-entry holding register per channel.
- Has a global enable, and drops and counts transfers whose select is out of range.
- Sits between a single producer and N independent consumers.

Parameters:
- DATA_W, 8: payload width in bits.
- N_OUT, 4: number of output channels, >= 2.
- SEL_W, 2: select width; must satisfy 2^SEL_W >= N_OUT.
- CNT_W, 8: width of the drop counter.

Ports:
- clk  input  1  clock; everything updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable; gates acceptance, like the x input of the 1-to-4 demux.
- in_data  input  DATA_W  payload.
- in_sel  input  SEL_W  destination channel index.
- in_valid  input  1  producer has a transfer.
- in_ready  output  1  block accepts this cycle; combinational.
- out_data  output  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  N_OUT  channel k holds data.
- out_ready  input  N_OUT  consumer k accepts.
- drop_err  output  1  one-cycle pulse when a transfer is dropped.
- drop_cnt  output  CNT_W  count of dropped transfers, saturating.

Behaviour:
- Reset (async assert, released synchronously to clk): out_valid=0, out_data=0, drop_err=0, drop_cnt=0. While rst is high, in_ready=0.
- Input handshake:
  - An input transfer occurs when in_valid && in_ready at the clock edge.
  - Producer must hold in_data and in_sel stable while in_valid && !in_ready.
- in_ready is combinational from en, in_sel, out_valid and out_ready. It never depends on in_valid.
  - en=0: in_ready=0.
  - en=1 and in_sel < N_OUT: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - en=1 and in_sel >= N_OUT: in_ready=1 (transfer is accepted so it can be dropped).
- Valid-select transfer:
  - Next cycle, out_data[in_sel] = in_data and out_valid[in_sel] = 1.
  - Latency is exactly 1 cycle.
  - Other channels are unaffected.
- Output handshake: channel k completes when out_valid[k] && out_ready[k].
  - If there is no simultaneous load into k, out_valid[k] clears next cycle.
  - If a load into k happens in the same cycle, out_valid[k] stays 1 and out_data[k] takes the new value. This gives full throughput of one transfer per cycle per channel.
- out_data[k] holds its last value while out_valid[k]=0. It is only rewritten on a load into k.
- Out-of-range select (in_sel >= N_OUT, possible only when 2^SEL_W > N_OUT):
  - No channel is written.
  - drop_err=1 for the next cycle only.
  - drop_cnt increments by 1 and saturates at 2^CNT_W-1 with no wrap.
- drop_err is registered and is 0 in every cycle that does not follow a drop.
- Dropping en mid-stream:
  - Stops new acceptances only.
  - Loaded channels keep out_valid and still drain via out_ready.
- Reset asserted mid-operation:
  - All held data is discarded immediately, regardless of pending out_ready.
  - The drop count is lost.
- Channels are independent. One stalled consumer blocks only transfers selecting it; the producer may switch in_sel while stalled (valid is not withdrawn, but the target may change).

Test Plan:
- Reset, en=1, all out_ready=1; send in_data=0xA5 with in_sel=0, 1, 2, 3 on consecutive cycles → out_valid is one-hot 0001, 0010, 0100, 1000, one cycle after each send, with out_data slice = 0xA5 each time; in_ready constantly 1.
- out_ready[2]=0; send 0x11 then 0x22 to sel=2 → first accepted; second sees in_ready=0 and stalls with out_data[2]=0x11 held; raise out_ready[2] → 0x22 is loaded in the same cycle 0x11 completes and out_valid[2] stays 1.
- en=0, in_valid=1, sel=1 → in_ready=0 and no out_valid change; set en=1 → accepted with 1-cycle latency.
- N_OUT=3, SEL_W=2; send sel=3 with 0x7F five times → no out_valid rises, drop_err pulses five times, drop_cnt=5.
- CNT_W=2; send 5 drops → drop_cnt reads 1, 2, 3, 3, 3 (saturates).
- Load channels 0 and 1 with out_ready=0, assert rst asynchronously mid-cycle → out_valid=0, out_data=0 and drop_cnt=0 immediately, before the next clk edge.
